// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants, encodings and types for the pipeline control unit.
package mips_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct codes that need special handling
  localparam logic [5:0] FN_JR = 6'b001000;

  // ALUOp codes
  localparam logic [2:0] ALU_RTYPE = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SLT   = 3'd6;

  // RegDst select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // ALUSrc select
  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_ZERO = 2'b10;

  // MemSize encoding
  localparam logic [1:0] MS_WORD = 2'b00;
  localparam logic [1:0] MS_HALF = 2'b01;
  localparam logic [1:0] MS_BYTE = 2'b10;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic [1:0] alu_src;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] mem_size;
  } ctrl_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      OP_XORI: imm_alu_op = ALU_XOR;
      OP_SLTI: imm_alu_op = ALU_SLT;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] mem_size_of(input logic [5:0] op);
    case (op)
      OP_LH, OP_SH: mem_size_of = MS_HALF;
      OP_LB, OP_SB: mem_size_of = MS_BYTE;
      default:      mem_size_of = MS_WORD;
    endcase
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_REGIMM) ||
                (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: the instruction in decode reads the register a load
// issued last cycle is still fetching.
module hazard_detect
  import mips_ctrl_pkg::*;
(
  input  logic       i_prev_memread,
  input  logic [4:0] i_prev_rt,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic [5:0] i_opcode,
  output logic       o_hazard
);

  logic w_rt_is_source;

  // rt is only a source operand for R-type, branches and stores.
  always_comb begin
    w_rt_is_source = (i_opcode == OP_RTYPE) || is_branch(i_opcode) || is_store(i_opcode);
  end

  // $0 never carries a pending load value, so it can never cause a stall.
  always_comb begin
    o_hazard = i_prev_memread && (i_prev_rt != 5'd0) &&
               ((i_rs == i_prev_rt) || (w_rt_is_source && (i_rt == i_prev_rt)));
  end

endmodule

// File: rtl/pipe_controller.sv
// Decode-stage control unit: registered control word, load-use stall,
// flush bubbling and illegal-opcode tracking.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RUN   | normal decode; Stall and illegal detection active
//   ST_FLUSH | squashing; r_flush_cnt counts down, the cycle with count 1
//            | lets the next instruction through so exactly FLUSH_DEPTH
//            | bubbles reach the outputs
module pipe_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 8,
  parameter int EN_JUMP     = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [31:0]        Instruction,
  input  logic               InstrValid,
  input  logic               Flush,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         ALUSrc,
  output logic               Branch,
  output logic               Jump,
  output logic               JumpReg,
  output logic               Link,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               CtrlValid,
  output logic [1:0]         MemSize,
  output logic               Stall,
  output logic               IllegalOp,
  output logic [CNT_W-1:0]   IllegalCount
);

  localparam logic [2:0] LP_DEPTH = 3'(FLUSH_DEPTH);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic       w_unused_bits;

  assign w_op          = Instruction[31:26];
  assign w_rs          = Instruction[25:21];
  assign w_rt          = Instruction[20:16];
  assign w_funct       = Instruction[5:0];
  assign w_unused_bits = ^Instruction[15:6];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_cnt_nxt;

  ctrl_t            r_ctrl;
  logic             r_ctrl_valid;
  logic             r_illegal;
  logic [4:0]       r_prev_rt;
  logic [CNT_W-1:0] r_illegal_count;

  ctrl_t      w_dec;
  logic       w_dec_illegal;
  logic       w_hazard;
  logic       w_squash;
  logic       w_bubble;
  ctrl_t      w_ctrl_nxt;
  logic       w_valid_nxt;
  logic       w_illegal_nxt;
  logic [4:0] w_prev_rt_nxt;

  hazard_detect u_hazard (
    .i_prev_memread (r_ctrl.mem_read),
    .i_prev_rt      (r_prev_rt),
    .i_rs           (w_rs),
    .i_rt           (w_rt),
    .i_opcode       (w_op),
    .o_hazard       (w_hazard)
  );

  // Flush wins over everything; a stall is only meaningful while running.
  assign Stall = w_hazard && InstrValid && !Flush && (r_state == ST_RUN);

  // Decode table: one control word per opcode, unlisted fields stay zero.
  always_comb begin
    w_dec         = '0;
    w_dec_illegal = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FN_JR) begin
          if (EN_JUMP != 0) w_dec.jump_reg = 1'b1;
          else              w_dec_illegal  = 1'b1;
        end else begin
          w_dec.reg_dst    = RD_RD;
          w_dec.alu_op     = ALU_RTYPE;
          w_dec.reg_write  = 1'b1;
          w_dec.mem_to_reg = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        w_dec.reg_dst    = RD_RT;
        w_dec.alu_op     = imm_alu_op(w_op);
        w_dec.alu_src    = SRC_IMM;
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 1'b1;
      end
      OP_LW, OP_LH, OP_LB: begin
        w_dec.alu_op    = ALU_ADD;
        w_dec.alu_src   = SRC_IMM;
        w_dec.mem_read  = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.mem_size  = mem_size_of(w_op);
      end
      OP_SW, OP_SH, OP_SB: begin
        w_dec.alu_op    = ALU_ADD;
        w_dec.alu_src   = SRC_IMM;
        w_dec.mem_write = 1'b1;
        w_dec.mem_size  = mem_size_of(w_op);
      end
      OP_BEQ, OP_BNE, OP_REGIMM: begin
        w_dec.alu_op  = ALU_SUB;
        w_dec.alu_src = SRC_REG;
        w_dec.branch  = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: begin
        w_dec.alu_op  = ALU_SUB;
        w_dec.alu_src = SRC_ZERO;
        w_dec.branch  = 1'b1;
      end
      OP_J: begin
        if (EN_JUMP != 0) w_dec.jump    = 1'b1;
        else              w_dec_illegal = 1'b1;
      end
      OP_JAL: begin
        if (EN_JUMP != 0) begin
          w_dec.jump      = 1'b1;
          w_dec.link      = 1'b1;
          w_dec.reg_dst   = RD_RA;
          w_dec.reg_write = 1'b1;
        end else begin
          w_dec_illegal = 1'b1;
        end
      end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Next state / flush counter; a Flush in FLUSH restarts the count.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_squash        = 1'b0;
    if (Flush) begin
      w_state_nxt     = ST_FLUSH;
      w_flush_cnt_nxt = LP_DEPTH;
      w_squash        = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      if (r_flush_cnt <= 3'd1) begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = 3'd0;
      end else begin
        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        w_squash        = 1'b1;
      end
    end
  end

  // Select decoded word or bubble for the output register.
  always_comb begin
    w_bubble      = w_squash || Stall || !InstrValid;
    w_ctrl_nxt    = w_bubble ? '0 : w_dec;
    w_valid_nxt   = !w_bubble;
    w_illegal_nxt = !w_bubble && w_dec_illegal;
    w_prev_rt_nxt = w_bubble ? 5'd0 : w_rt;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Output register stage, hazard tracking and saturating illegal counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ctrl          <= '0;
      r_ctrl_valid    <= 1'b0;
      r_illegal       <= 1'b0;
      r_prev_rt       <= 5'd0;
      r_illegal_count <= '0;
    end else begin
      r_ctrl       <= w_ctrl_nxt;
      r_ctrl_valid <= w_valid_nxt;
      r_illegal    <= w_illegal_nxt;
      r_prev_rt    <= w_prev_rt_nxt;
      if (w_illegal_nxt && (r_illegal_count != '1))
        r_illegal_count <= r_illegal_count + CNT_W'(1);
    end
  end

  assign RegDst       = r_ctrl.reg_dst;
  assign ALUOp        = ALUOP_W'(r_ctrl.alu_op);
  assign ALUSrc       = r_ctrl.alu_src;
  assign Branch       = r_ctrl.branch;
  assign Jump         = r_ctrl.jump;
  assign JumpReg      = r_ctrl.jump_reg;
  assign Link         = r_ctrl.link;
  assign MemRead      = r_ctrl.mem_read;
  assign MemWrite     = r_ctrl.mem_write;
  assign MemtoReg     = r_ctrl.mem_to_reg;
  assign RegWrite     = r_ctrl.reg_write;
  assign MemSize      = r_ctrl.mem_size;
  assign CtrlValid    = r_ctrl_valid;
  assign IllegalOp    = r_illegal;
  assign IllegalCount = r_illegal_count;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: decode table plus stall, flush,
// saturation, jump-disable and mid-flush reset sequences.
module tb_pipe_controller;

  typedef struct packed {
    logic       v;
    logic       ill;
    logic [1:0] rd;
    logic [2:0] op;
    logic [1:0] src;
    logic [7:0] f;    // branch, jump, jumpreg, link, memread, memwrite, memtoreg, regwrite
    logic [1:0] ms;
  } ctl_t;

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    ctl_t        exp;
  } vec_t;

  localparam ctl_t BUB = '0;
  localparam ctl_t ILL = {2'b11, 17'd0};

  localparam logic [31:0] I_LW    = 32'h8C090000;
  localparam logic [31:0] I_ADD10 = 32'h01295020;
  localparam logic [31:0] I_ADDI  = 32'h20080005;
  localparam logic [31:0] I_JAL   = 32'h0C000010;
  localparam logic [31:0] I_JR    = 32'h03E00008;
  localparam logic [31:0] I_BAD   = 32'hFC000000;

  function automatic ctl_t C(input logic [1:0] rd, input logic [2:0] op,
                             input logic [1:0] src, input logic [7:0] f,
                             input logic [1:0] ms);
    C = {1'b1, 1'b0, rd, op, src, f, ms};
  endfunction

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] Instruction = 32'd0;
  logic        InstrValid = 1'b0;
  logic        Flush = 1'b0;

  always #5 Clk = ~Clk;

  logic [1:0] a_RegDst, a_ALUSrc, a_MemSize;
  logic [2:0] a_ALUOp;
  logic a_Branch, a_Jump, a_JumpReg, a_Link, a_MemRead, a_MemWrite, a_MemtoReg, a_RegWrite;
  logic a_CtrlValid, a_Stall, a_IllegalOp;
  logic [7:0] a_IllegalCount;

  logic [1:0] b_RegDst, b_ALUSrc, b_MemSize;
  logic [2:0] b_ALUOp;
  logic b_Branch, b_Jump, b_JumpReg, b_Link, b_MemRead, b_MemWrite, b_MemtoReg, b_RegWrite;
  logic b_CtrlValid, b_Stall, b_IllegalOp;
  logic [7:0] b_IllegalCount;

  pipe_controller #(.ALUOP_W(3), .FLUSH_DEPTH(2), .CNT_W(8), .EN_JUMP(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid), .Flush(Flush),
    .RegDst(a_RegDst), .ALUOp(a_ALUOp), .ALUSrc(a_ALUSrc), .Branch(a_Branch), .Jump(a_Jump),
    .JumpReg(a_JumpReg), .Link(a_Link), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
    .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .CtrlValid(a_CtrlValid), .MemSize(a_MemSize),
    .Stall(a_Stall), .IllegalOp(a_IllegalOp), .IllegalCount(a_IllegalCount)
  );

  pipe_controller #(.ALUOP_W(3), .FLUSH_DEPTH(3), .CNT_W(8), .EN_JUMP(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .InstrValid(InstrValid), .Flush(Flush),
    .RegDst(b_RegDst), .ALUOp(b_ALUOp), .ALUSrc(b_ALUSrc), .Branch(b_Branch), .Jump(b_Jump),
    .JumpReg(b_JumpReg), .Link(b_Link), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .CtrlValid(b_CtrlValid), .MemSize(b_MemSize),
    .Stall(b_Stall), .IllegalOp(b_IllegalOp), .IllegalCount(b_IllegalCount)
  );

  ctl_t a_o, b_o;
  always_comb a_o = {a_CtrlValid, a_IllegalOp, a_RegDst, a_ALUOp, a_ALUSrc, a_Branch, a_Jump,
                     a_JumpReg, a_Link, a_MemRead, a_MemWrite, a_MemtoReg, a_RegWrite, a_MemSize};
  always_comb b_o = {b_CtrlValid, b_IllegalOp, b_RegDst, b_ALUOp, b_ALUSrc, b_Branch, b_Jump,
                     b_JumpReg, b_Link, b_MemRead, b_MemWrite, b_MemtoReg, b_RegWrite, b_MemSize};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic f);
    Instruction = ins;
    InstrValid  = v;
    Flush       = f;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(32'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  vec_t tv[$];
  int   exp_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {instr, valid, expected registered controls}
    tv.push_back('{32'h00221820, 1'b1, C(2'b01, 3'd0, 2'b00, 8'b0000_0011, 2'b00)}); // add
    tv.push_back('{32'h00221822, 1'b1, C(2'b01, 3'd0, 2'b00, 8'b0000_0011, 2'b00)}); // sub
    tv.push_back('{32'h20080005, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_0011, 2'b00)}); // addi
    tv.push_back('{32'h302400FF, 1'b1, C(2'b00, 3'd3, 2'b01, 8'b0000_0011, 2'b00)}); // andi
    tv.push_back('{32'h34250001, 1'b1, C(2'b00, 3'd4, 2'b01, 8'b0000_0011, 2'b00)}); // ori
    tv.push_back('{32'h38260001, 1'b1, C(2'b00, 3'd5, 2'b01, 8'b0000_0011, 2'b00)}); // xori
    tv.push_back('{32'h28270001, 1'b1, C(2'b00, 3'd6, 2'b01, 8'b0000_0011, 2'b00)}); // slti
    tv.push_back('{32'h8C090000, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_1001, 2'b00)}); // lw
    tv.push_back('{32'h8C090000, 1'b0, BUB});                                         // idle
    tv.push_back('{32'h842A0002, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_1001, 2'b01)}); // lh
    tv.push_back('{32'hFFFFFFFF, 1'b0, BUB});                                         // idle
    tv.push_back('{32'h802B0003, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_1001, 2'b10)}); // lb
    tv.push_back('{32'h00000000, 1'b0, BUB});                                         // idle
    tv.push_back('{32'hAC220004, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_0100, 2'b00)}); // sw
    tv.push_back('{32'hA4220004, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_0100, 2'b01)}); // sh
    tv.push_back('{32'hA0220004, 1'b1, C(2'b00, 3'd1, 2'b01, 8'b0000_0100, 2'b10)}); // sb
    tv.push_back('{32'h10220004, 1'b1, C(2'b00, 3'd2, 2'b00, 8'b1000_0000, 2'b00)}); // beq
    tv.push_back('{32'h14220004, 1'b1, C(2'b00, 3'd2, 2'b00, 8'b1000_0000, 2'b00)}); // bne
    tv.push_back('{32'h04210004, 1'b1, C(2'b00, 3'd2, 2'b00, 8'b1000_0000, 2'b00)}); // regimm
    tv.push_back('{32'h18200004, 1'b1, C(2'b00, 3'd2, 2'b10, 8'b1000_0000, 2'b00)}); // blez
    tv.push_back('{32'h1C200004, 1'b1, C(2'b00, 3'd2, 2'b10, 8'b1000_0000, 2'b00)}); // bgtz
    tv.push_back('{32'h08000010, 1'b1, C(2'b00, 3'd0, 2'b00, 8'b0100_0000, 2'b00)}); // j
    tv.push_back('{32'h0C000010, 1'b1, C(2'b10, 3'd0, 2'b00, 8'b0101_0001, 2'b00)}); // jal
    tv.push_back('{32'h03E00008, 1'b1, C(2'b00, 3'd0, 2'b00, 8'b0010_0000, 2'b00)}); // jr
    tv.push_back('{32'hFC000000, 1'b1, ILL});                                         // op 111111
    tv.push_back('{32'h40000000, 1'b1, ILL});                                         // op 010000

    // Reset: outputs forced low immediately and held low across edges.
    #3 Rst = 1'b0;
    #1;
    chk("rst_a_out", a_o, BUB);
    chk("rst_a_stall", a_Stall, 1'b0);
    chk("rst_a_cnt", a_IllegalCount, 8'd0);
    chk("rst_b_out", b_o, BUB);
    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    tick();
    chk("rst_hold_a", a_o, BUB);
    chk("rst_hold_stall", a_Stall, 1'b0);
    Rst = 1'b1;

    // Decode table.
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].instr, tv[i].vld, 1'b0);
      tick();
      chk($sformatf("vec%0d", i), a_o, tv[i].exp);
    end
    exp_cnt = 2;
    chk("cnt_after_table", a_IllegalCount, exp_cnt);

    // Load-use: one-cycle stall, one bubble, then the dependent add.
    idle(2);
    drive(I_LW, 1'b1, 1'b0);
    tick();
    chk("lu_lw", a_o, C(2'b00, 3'd1, 2'b01, 8'b0000_1001, 2'b00));
    drive(I_ADD10, 1'b1, 1'b0);
    #1 chk("lu_stall_hi", a_Stall, 1'b1);
    tick();
    chk("lu_bubble", a_o, BUB);
    #1 chk("lu_stall_lo", a_Stall, 1'b0);
    tick();
    chk("lu_add", a_o, C(2'b01, 3'd0, 2'b00, 8'b0000_0011, 2'b00));

    // Flush with a stall-causing instruction (depth 2): no stall, two bubbles.
    idle(2);
    drive(I_LW, 1'b1, 1'b0);
    tick();
    chk("fl_lw", a_o, C(2'b00, 3'd1, 2'b01, 8'b0000_1001, 2'b00));
    drive(I_ADD10, 1'b1, 1'b1);
    #1 chk("fl_no_stall", a_Stall, 1'b0);
    tick();
    chk("fl_bub1", a_o, BUB);
    drive(I_ADD10, 1'b1, 1'b0);
    #1 chk("fl_stall_in_flush", a_Stall, 1'b0);
    tick();
    chk("fl_bub2", a_o, BUB);
    tick();
    chk("fl_run", a_o, C(2'b01, 3'd0, 2'b00, 8'b0000_0011, 2'b00));

    // Flush arriving while flushing restarts the bubble count.
    idle(2);
    drive(I_ADDI, 1'b1, 1'b1);
    tick();
    chk("re_bub1", a_o, BUB);
    drive(I_ADDI, 1'b1, 1'b1);
    tick();
    chk("re_bub2", a_o, BUB);
    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    chk("re_bub3", a_o, BUB);
    tick();
    chk("re_run", a_o, C(2'b00, 3'd1, 2'b01, 8'b0000_0011, 2'b00));

    // 300 illegal opcodes: IllegalOp pulses, count saturates at 255.
    idle(4);
    for (int i = 0; i < 300; i++) begin
      drive(I_BAD, 1'b1, 1'b0);
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk($sformatf("sat_ill%0d", i), a_IllegalOp, 1'b1);
      chk($sformatf("sat_cnt%0d", i), a_IllegalCount, exp_cnt);
      drive(32'd0, 1'b0, 1'b0);
      tick();
      chk($sformatf("sat_low%0d", i), a_IllegalOp, 1'b0);
    end
    chk("sat_a_final", a_IllegalCount, 8'd255);
    chk("sat_b_final", b_IllegalCount, 8'd255);

    // jal / jr with jumps enabled (a) and disabled (b).
    idle(2);
    drive(I_JAL, 1'b1, 1'b0);
    tick();
    chk("jal_a", a_o, C(2'b10, 3'd0, 2'b00, 8'b0101_0001, 2'b00));
    chk("jal_b_illegal", b_o, ILL);
    drive(I_JR, 1'b1, 1'b0);
    tick();
    chk("jr_a_jumpreg", a_JumpReg, 1'b1);
    chk("jr_a_regwrite", a_RegWrite, 1'b0);
    chk("jr_b_illegal", b_o, ILL);

    // Reset in the middle of a depth-3 flush, then normal decode on release.
    idle(2);
    drive(I_ADDI, 1'b1, 1'b1);
    tick();
    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    chk("mid_b_bubble", b_o, BUB);
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_b_out", b_o, BUB);
    chk("mid_rst_b_stall", b_Stall, 1'b0);
    chk("mid_rst_b_cnt", b_IllegalCount, 8'd0);
    chk("mid_rst_a_cnt", a_IllegalCount, 8'd0);
    tick();
    chk("mid_rst_hold_b", b_o, BUB);
    #2 Rst = 1'b1;
    drive(I_ADDI, 1'b1, 1'b0);
    tick();
    chk("post_rst_b_addi", b_o, C(2'b00, 3'd1, 2'b01, 8'b0000_0011, 2'b00));
    chk("post_rst_a_addi", a_o, C(2'b00, 3'd1, 2'b01, 8'b0000_0011, 2'b00));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 SHALL have parameter ALUOP_W, default 3, ALUOp width, legal range 3 or more.
REQ-002 SHALL have parameter FLUSH_DEPTH, default 1, number of bubble cycles per flush, legal range 1 to 7.
REQ-003 SHALL have parameter CNT_W, default 8, IllegalCount width.
REQ-004 SHALL have parameter EN_JUMP, default 1; when 0, the j, jal and jr encodings are illegal.
REQ-005 SHALL have port Clk, in, 1 bit, the only clock; all state updates on the rising edge.
REQ-006 SHALL have port Rst, in, 1 bit, asynchronous, active-low reset.
REQ-007 SHALL have port Instruction, in, 32 bits, instruction in decode.
REQ-008 SHALL have port InstrValid, in, 1 bit; Instruction is meaningful only while it is high.
REQ-009 SHALL have port Flush, in, 1 bit, one-cycle pulse from the branch/jump resolution stage.
REQ-010 SHALL have port RegDst, out, 2 bits: 00 = rt, 01 = rd, 10 = $31.
REQ-011 SHALL have ports ALUOp (out, ALUOP_W bits) and ALUSrc (out, 2 bits: 00 = reg, 01 = imm, 10 = zero).
REQ-012 SHALL have 1-bit outputs Branch, Jump, JumpReg, Link, MemRead, MemWrite, MemtoReg, RegWrite and CtrlValid.
REQ-013 SHALL have port MemSize, out, 2 bits: 00 = word, 01 = half, 10 = byte.
REQ-014 SHALL have outputs Stall (combinational, 1 bit), IllegalOp (registered, 1 bit) and IllegalCount (CNT_W bits).

Function
REQ-015 SHALL register all control outputs except Stall, giving decode-to-output latency of exactly 1 cycle.
REQ-016 SHALL decode the following opcodes, with MemtoReg=1 selecting the ALU result:
  - R-type 000000: RegDst=01, ALUOp=000, RegWrite=1, MemtoReg=1.
  - addi 001000 (ALUOp=001), andi 001100 (011), ori 001101 (100), xori 001110 (101), slti 001010 (110): RegDst=00, ALUSrc=01, RegWrite=1, MemtoReg=1.
  - lw 100011, lh 100001, lb 100000: ALUOp=001, ALUSrc=01, MemRead=1, RegWrite=1, MemtoReg=0, MemSize per REQ-013.
  - sw 101011, sh 101001, sb 101000: ALUOp=001, ALUSrc=01, MemWrite=1, MemSize per REQ-013.
  - beq 000100, bne 000101 and regimm 000001: ALUOp=010, ALUSrc=00, Branch=1.
  - blez 000110 and bgtz 000111: ALUOp=010, ALUSrc=10, Branch=1.
  - j 000010: Jump=1.
  - jal 000011: Jump=1, Link=1, RegDst=10, RegWrite=1.
  - jr (opcode 000000, funct 001000): JumpReg=1, RegWrite=0.
REQ-017 SHALL drive every control field not listed for a decoded instruction to 0.
REQ-018 SHALL treat any other opcode as illegal: all controls 0, CtrlValid=1, IllegalOp=1 for that one cycle.
REQ-019 SHALL increment IllegalCount once per illegal instruction and saturate at all-ones, with no wrap-around.
REQ-020 SHALL produce a bubble when InstrValid=0: all controls 0 and CtrlValid=0.
REQ-021 SHALL hold the previous cycle's registered MemRead together with its destination register (rt).
REQ-022 SHALL assert Stall in the same cycle when a valid instruction reads that held register.
  - Condition: previous MemRead=1, previous rt != 0, and rs==prev_rt, or rt==prev_rt for R-type, branch or store.
REQ-023 SHALL, on Stall, register a bubble next cycle; upstream holds Instruction, so Stall lasts exactly 1 cycle.
REQ-024 SHALL implement a two-state FSM, RUN and FLUSH, plus a 3-bit flush counter.
  - RUN -> FLUSH when Flush=1; the counter loads FLUSH_DEPTH and the bubble begins next cycle.
  - In FLUSH, outputs are bubbles, Stall=0 and illegal detection is suppressed.
  - The counter decrements each cycle; FLUSH -> RUN when it reaches 1.
REQ-025 SHALL restart the counter at FLUSH_DEPTH when Flush=1 arrives while already in FLUSH.
REQ-026 SHALL give Flush priority over Stall and over illegal detection when both occur in the same cycle.
REQ-027 SHALL produce no X on any output while InstrValid=0, regardless of the value of Instruction.

Reset
REQ-028 SHALL, while Rst=0, immediately force all registered outputs to 0, IllegalCount to 0, the FSM to RUN, the counter to 0 and the hazard register to 0.
REQ-029 SHALL hold Stall at 0 during reset.
REQ-030 SHALL discard any in-progress flush or stall when reset occurs mid-operation; the first valid instruction after release decodes normally.

Structure
REQ-031 SHALL place opcode and funct constants, the ALUOp codes, the RegDst/ALUSrc/MemSize encodings and the FSM state type in shared package mips_ctrl_pkg.
REQ-032 SHALL use one sub-module, hazard_detect, containing the combinational Stall logic of REQ-022, taking the held prev MemRead and prev rt plus the current rs, rt and opcode.
REQ-033 SHALL keep the decode table as a single combinational block feeding one output register stage.

Verification
REQ-034 SHALL verify: Rst low mid-flush with FLUSH_DEPTH=3 -> all outputs 0 immediately; after release, addi 0x20080005 decodes to RegWrite=1, ALUSrc=01, ALUOp=001 one cycle later.
REQ-035 SHALL verify: lw 0x8C090000 followed by add $10,$9,$9 -> Stall=1 for one cycle, one bubble, then the add appears with RegDst=01.
REQ-036 SHALL verify: Flush=1 together with a Stall-causing instruction, FLUSH_DEPTH=2 -> exactly 2 bubble cycles, no stall, then RUN.
REQ-037 SHALL verify: opcode 111111 applied 300 times with CNT_W=8 -> IllegalOp pulses each time and IllegalCount saturates at 255.
REQ-038 SHALL verify: jal 0x0C000010 -> Jump=1, Link=1, RegDst=10, RegWrite=1; with EN_JUMP=0 the same word gives IllegalOp=1.
REQ-039 SHALL verify: jr (0x03E00008) -> JumpReg=1 and RegWrite=0.
